// File: rtl/pipe_flush_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_flush_regs                                               |
// | Brief    : PC, IF/ID and ID/EX pipeline registers with per-register      |
// |            load/hold/clear control, stall/flush counters, illegal flag.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module pipe_flush_regs #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  PCFlush,
    input  logic [1:0]  IFIDFlush,
    input  logic [1:0]  IDEXFlush,
    input  logic [31:0] PCNext,
    input  logic [31:0] InstIF,
    input  logic [31:0] PCPlus4IF,
    input  logic [15:0] CtrlID,
    input  logic [4:0]  RsID,
    input  logic [4:0]  RtID,
    input  logic [4:0]  RdID,
    output logic [31:0] PC,
    output logic [31:0] InstID,
    output logic [31:0] PCPlus4ID,
    output logic        ValidID,
    output logic [15:0] CtrlEX,
    output logic [4:0]  RsEX,
    output logic [4:0]  RtEX,
    output logic [4:0]  RdEX,
    output logic [31:0] PCPlus4EX,
    output logic        ValidEX,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount,
    output logic        IllegalCode
);

    localparam logic [1:0]  c_LOAD    = 2'b00;
    localparam logic [1:0]  c_HOLD    = 2'b10;
    localparam logic [1:0]  c_CLEAR   = 2'b01;
    localparam logic [1:0]  c_ILLEGAL = 2'b11;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic        w_pc_load;
    logic        w_ifid_load;
    logic        w_ifid_clear;
    logic        w_idex_load;
    logic        w_idex_clear;
    logic        w_stall_evt;
    logic        w_flush_evt;
    logic        w_illegal_evt;

    logic [31:0] r_pc;
    logic [31:0] r_inst_id;
    logic [31:0] r_pc4_id;
    logic        r_valid_id;
    logic [15:0] r_ctrl_ex;
    logic [4:0]  r_rs_ex;
    logic [4:0]  r_rt_ex;
    logic [4:0]  r_rd_ex;
    logic [31:0] r_pc4_ex;
    logic        r_valid_ex;
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;
    logic        r_illegal;

    // The PC has nothing to clear, so a clear code simply loads the next PC.
    assign w_pc_load     = (PCFlush == c_LOAD) || (PCFlush == c_CLEAR);
    assign w_ifid_load   = (IFIDFlush == c_LOAD);
    assign w_ifid_clear  = (IFIDFlush == c_CLEAR);
    assign w_idex_load   = (IDEXFlush == c_LOAD);
    assign w_idex_clear  = (IDEXFlush == c_CLEAR);
    assign w_stall_evt   = (PCFlush == c_HOLD);
    assign w_flush_evt   = w_ifid_clear || w_idex_clear;
    assign w_illegal_evt = (PCFlush == c_ILLEGAL) || (IFIDFlush == c_ILLEGAL) ||
                           (IDEXFlush == c_ILLEGAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (w_pc_load) begin
            r_pc <= PCNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inst_id  <= NOP_INST;
            r_pc4_id   <= 32'd0;
            r_valid_id <= 1'b0;
        end else if (w_ifid_load) begin
            r_inst_id  <= InstIF;
            r_pc4_id   <= PCPlus4IF;
            r_valid_id <= 1'b1;
        end else if (w_ifid_clear) begin
            r_inst_id  <= NOP_INST;
            r_pc4_id   <= 32'd0;
            r_valid_id <= 1'b0;
        end
    end

    // A bubble in IF/ID must never carry live control into EX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl_ex  <= 16'd0;
            r_rs_ex    <= 5'd0;
            r_rt_ex    <= 5'd0;
            r_rd_ex    <= 5'd0;
            r_pc4_ex   <= 32'd0;
            r_valid_ex <= 1'b0;
        end else if (w_idex_load) begin
            r_ctrl_ex  <= r_valid_id ? CtrlID : 16'd0;
            r_rs_ex    <= RsID;
            r_rt_ex    <= RtID;
            r_rd_ex    <= RdID;
            r_pc4_ex   <= r_pc4_id;
            r_valid_ex <= r_valid_id;
        end else if (w_idex_clear) begin
            r_ctrl_ex  <= 16'd0;
            r_rs_ex    <= 5'd0;
            r_rt_ex    <= 5'd0;
            r_rd_ex    <= 5'd0;
            r_pc4_ex   <= 32'd0;
            r_valid_ex <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= 16'd0;
            r_flush_count <= 16'd0;
            r_illegal     <= 1'b0;
        end else begin
            if (w_stall_evt && (r_stall_count != c_CNT_MAX)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
            if (w_flush_evt && (r_flush_count != c_CNT_MAX)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
            if (w_illegal_evt) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign PC          = r_pc;
    assign InstID      = r_inst_id;
    assign PCPlus4ID   = r_pc4_id;
    assign ValidID     = r_valid_id;
    assign CtrlEX      = r_ctrl_ex;
    assign RsEX        = r_rs_ex;
    assign RtEX        = r_rt_ex;
    assign RdEX        = r_rd_ex;
    assign PCPlus4EX   = r_pc4_ex;
    assign ValidEX     = r_valid_ex;
    assign StallCount  = r_stall_count;
    assign FlushCount  = r_flush_count;
    assign IllegalCode = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_pipe_flush_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pipe_flush_regs                                            |
// | Brief    : Self-checking bench for pipe_flush_regs with a reference      |
// |            model of the pipeline registers and counters.                 |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_pipe_flush_regs;

    localparam logic [31:0] c_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [1:0]  PCFlush, IFIDFlush, IDEXFlush;
    logic [31:0] PCNext, InstIF, PCPlus4IF;
    logic [15:0] CtrlID;
    logic [4:0]  RsID, RtID, RdID;
    logic [31:0] PC, InstID, PCPlus4ID, PCPlus4EX;
    logic        ValidID, ValidEX, IllegalCode;
    logic [15:0] CtrlEX, StallCount, FlushCount;
    logic [4:0]  RsEX, RtEX, RdEX;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_inst_id, m_pc4_id, m_pc4_ex;
    logic        m_valid_id, m_valid_ex, m_ill;
    logic [15:0] m_ctrl_ex;
    logic [4:0]  m_rs, m_rt, m_rd;
    int          m_stall, m_flush;

    pipe_flush_regs #(.RESET_PC(c_RESET_PC), .NOP_INST(c_NOP)) dut (
        .clk(clk), .reset(reset),
        .PCFlush(PCFlush), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
        .PCNext(PCNext), .InstIF(InstIF), .PCPlus4IF(PCPlus4IF),
        .CtrlID(CtrlID), .RsID(RsID), .RtID(RtID), .RdID(RdID),
        .PC(PC), .InstID(InstID), .PCPlus4ID(PCPlus4ID), .ValidID(ValidID),
        .CtrlEX(CtrlEX), .RsEX(RsEX), .RtEX(RtEX), .RdEX(RdEX),
        .PCPlus4EX(PCPlus4EX), .ValidEX(ValidEX),
        .StallCount(StallCount), .FlushCount(FlushCount),
        .IllegalCode(IllegalCode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [193:0] dut_vec();
        return {PC, InstID, PCPlus4ID, ValidID, CtrlEX, RsEX, RtEX, RdEX,
                PCPlus4EX, ValidEX, StallCount, FlushCount, IllegalCode};
    endfunction

    function automatic logic [193:0] model_vec();
        return {m_pc, m_inst_id, m_pc4_id, m_valid_id, m_ctrl_ex, m_rs, m_rt, m_rd,
                m_pc4_ex, m_valid_ex, m_stall[15:0], m_flush[15:0], m_ill};
    endfunction

    task automatic model_reset();
        m_pc = c_RESET_PC; m_inst_id = c_NOP; m_pc4_id = '0; m_valid_id = 1'b0;
        m_ctrl_ex = '0; m_rs = '0; m_rt = '0; m_rd = '0; m_pc4_ex = '0;
        m_valid_ex = 1'b0; m_stall = 0; m_flush = 0; m_ill = 1'b0;
    endtask

    // One clock edge as the pipeline contract describes it; ID/EX reads the
    // IF/ID contents as they were before this edge.
    task automatic model_step();
        if (PCFlush == 2'b00 || PCFlush == 2'b01) m_pc = PCNext;
        if (IDEXFlush == 2'b00) begin
            m_ctrl_ex = m_valid_id ? CtrlID : 16'd0;
            m_rs = RsID; m_rt = RtID; m_rd = RdID;
            m_pc4_ex = m_pc4_id; m_valid_ex = m_valid_id;
        end else if (IDEXFlush == 2'b01) begin
            m_ctrl_ex = '0; m_rs = '0; m_rt = '0; m_rd = '0;
            m_pc4_ex = '0; m_valid_ex = 1'b0;
        end
        if (IFIDFlush == 2'b00) begin
            m_inst_id = InstIF; m_pc4_id = PCPlus4IF; m_valid_id = 1'b1;
        end else if (IFIDFlush == 2'b01) begin
            m_inst_id = c_NOP; m_pc4_id = '0; m_valid_id = 1'b0;
        end
        if (PCFlush == 2'b10) m_stall = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
        if (IFIDFlush == 2'b01 || IDEXFlush == 2'b01)
            m_flush = (m_flush + 1 > 65535) ? 65535 : m_flush + 1;
        if (PCFlush == 2'b11 || IFIDFlush == 2'b11 || IDEXFlush == 2'b11) m_ill = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_codes(input logic [1:0] pc_c, input logic [1:0] ifid_c,
                             input logic [1:0] idex_c);
        PCFlush = pc_c; IFIDFlush = ifid_c; IDEXFlush = idex_c;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        set_codes(2'b00, 2'b00, 2'b00);
        PCNext = 32'h1111_1111; InstIF = 32'h2222_2222;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (PC !== c_RESET_PC) begin
            n_errors++; $display("FAIL reset_pc: got %h want %h", PC, c_RESET_PC);
        end
        n_checks++;
        if (InstID !== c_NOP || ValidID !== 1'b0 || ValidEX !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid: got inst=%h vid=%b vex=%b want inst=%h vid=0 vex=0",
                     InstID, ValidID, ValidEX, c_NOP);
        end
        n_checks++;
        if (dut_vec() !== model_vec()) begin
            n_errors++; $display("FAIL reset_all: got %h want %h", dut_vec(), model_vec());
        end
        // Edges while reset is held must not disturb anything.
        @(posedge clk); #1;
        n_checks++;
        if (dut_vec() !== model_vec()) begin
            n_errors++; $display("FAIL reset_held: got %h want %h", dut_vec(), model_vec());
        end
        reset = 1'b0;
    endtask

    task automatic test_fill();
        set_codes(2'b00, 2'b00, 2'b00);
        PCNext = 32'h0040_0004; InstIF = 32'h8C01_0000; PCPlus4IF = 32'h0040_0004;
        CtrlID = 16'hA5C3; RsID = 5'd1; RtID = 5'd2; RdID = 5'd3;
        tick();
        n_checks++;
        if (PC !== 32'h0040_0004 || InstID !== 32'h8C01_0000 || ValidID !== 1'b1) begin
            n_errors++;
            $display("FAIL fill_ifid: got pc=%h inst=%h vid=%b want pc=00400004 inst=8c010000 vid=1",
                     PC, InstID, ValidID);
        end
        n_checks++;
        if (ValidEX !== 1'b0 || CtrlEX !== 16'h0) begin
            n_errors++;
            $display("FAIL fill_ex_early: got vex=%b ctrl=%h want vex=0 ctrl=0000", ValidEX, CtrlEX);
        end
        tick();
        n_checks++;
        if (ValidEX !== 1'b1 || CtrlEX !== 16'hA5C3 || PCPlus4EX !== 32'h0040_0004) begin
            n_errors++;
            $display("FAIL fill_idex: got vex=%b ctrl=%h pc4=%h want vex=1 ctrl=a5c3 pc4=00400004",
                     ValidEX, CtrlEX, PCPlus4EX);
        end
    endtask

    task automatic test_load_use();
        set_codes(2'b10, 2'b10, 2'b01);
        PCNext = 32'h0040_0008; InstIF = 32'hAAAA_5555; PCPlus4IF = 32'h0040_0008;
        tick();
        n_checks++;
        if (PC !== 32'h0040_0004 || InstID !== 32'h8C01_0000 || CtrlEX !== 16'h0 ||
            ValidEX !== 1'b0) begin
            n_errors++;
            $display("FAIL load_use_regs: got pc=%h inst=%h ctrl=%h vex=%b want pc=00400004 inst=8c010000 ctrl=0000 vex=0",
                     PC, InstID, CtrlEX, ValidEX);
        end
        n_checks++;
        if (StallCount !== 16'd1 || FlushCount !== 16'd1) begin
            n_errors++;
            $display("FAIL load_use_counts: got stall=%0d flush=%0d want stall=1 flush=1",
                     StallCount, FlushCount);
        end
    endtask

    task automatic test_branch();
        set_codes(2'b00, 2'b01, 2'b01);
        PCNext = 32'h0040_0100;
        tick();
        n_checks++;
        if (PC !== 32'h0040_0100 || InstID !== c_NOP || ValidID !== 1'b0 || ValidEX !== 1'b0) begin
            n_errors++;
            $display("FAIL branch_regs: got pc=%h inst=%h vid=%b vex=%b want pc=00400100 inst=%h vid=0 vex=0",
                     PC, InstID, ValidID, ValidEX, c_NOP);
        end
        n_checks++;
        if (FlushCount !== 16'd2 || StallCount !== 16'd1) begin
            n_errors++;
            $display("FAIL branch_counts: got stall=%0d flush=%0d want stall=1 flush=2",
                     StallCount, FlushCount);
        end
    endtask

    task automatic test_illegal();
        set_codes(2'b00, 2'b00, 2'b00);
        InstIF = 32'h1234_5678; PCPlus4IF = 32'h0040_0104; PCNext = 32'h0040_0104;
        tick();
        n_checks++;
        if (IllegalCode !== 1'b0) begin
            n_errors++; $display("FAIL illegal_clear: got %b want 0", IllegalCode);
        end
        set_codes(2'b00, 2'b11, 2'b00);
        InstIF = 32'hDEAD_BEEF; PCPlus4IF = 32'h0BAD_0BAD;
        tick();
        n_checks++;
        if (InstID !== 32'h1234_5678 || PCPlus4ID !== 32'h0040_0104 || IllegalCode !== 1'b1) begin
            n_errors++;
            $display("FAIL illegal_hold: got inst=%h pc4=%h ill=%b want inst=12345678 pc4=00400104 ill=1",
                     InstID, PCPlus4ID, IllegalCode);
        end
        set_codes(2'b00, 2'b00, 2'b00);
        tick();
        n_checks++;
        if (IllegalCode !== 1'b1 || InstID !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL illegal_sticky: got ill=%b inst=%h want ill=1 inst=deadbeef",
                     IllegalCode, InstID);
        end
    endtask

    function automatic logic [1:0] rand_code();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 2'b11;
        case (r % 3)
            0:       return 2'b00;
            1:       return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_codes(rand_code(), rand_code(), rand_code());
            PCNext = $urandom; InstIF = $urandom; PCPlus4IF = $urandom;
            CtrlID = 16'($urandom); RsID = 5'($urandom); RtID = 5'($urandom);
            RdID = 5'($urandom);
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        set_codes(2'b10, 2'b10, 2'b01);
        tick();
        tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec() !== model_vec() || StallCount !== 16'd0 || FlushCount !== 16'd0) begin
            n_errors++;
            $display("FAIL async_reset: got %h want %h", dut_vec(), model_vec());
        end
        #1;
        reset = 1'b0;
        set_codes(2'b00, 2'b00, 2'b00);
        PCNext = 32'h0050_0000; InstIF = 32'h0BEE_F000; PCPlus4IF = 32'h0050_0004;
        tick();
        n_checks++;
        if (PC !== 32'h0050_0000 || InstID !== 32'h0BEE_F000 || StallCount !== 16'd0 ||
            dut_vec() !== model_vec()) begin
            n_errors++;
            $display("FAIL after_reset: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_codes(2'b10, 2'b01, 2'b10);
        for (int i = 1; i <= 65540; i++) begin
            tick();
            if (i == 65534 || i == 65535) begin
                n_checks++;
                if (dut_vec() !== model_vec()) begin
                    n_errors++;
                    $display("FAIL sat_edge[%0d]: got %h want %h", i, dut_vec(), model_vec());
                end
            end
        end
        n_checks++;
        if (StallCount !== 16'hFFFF || FlushCount !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL saturation: got stall=%h flush=%h want stall=ffff flush=ffff",
                     StallCount, FlushCount);
        end
    endtask

    initial begin
        reset = 1'b1;
        set_codes(2'b00, 2'b00, 2'b00);
        PCNext = '0; InstIF = '0; PCPlus4IF = '0; CtrlID = '0;
        RsID = '0; RtID = '0; RdID = '0;
        model_reset();
        test_reset();
        test_fill();
        test_load_use();
        test_branch();
        test_illegal();
        test_random();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_flush_regs.md
PIPE_FLUSH_REGS -- requirements
Module: pipe_flush_regs

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0040_0000, the PC value loaded on reset.
REQ-002 The module SHALL have parameter NOP_INST, default 32'h0000_0000, the instruction word inserted as a bubble.
REQ-003 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Ports:
  clk  in  1  rising-edge clock
  reset  in  1  async active-high reset
  PCFlush  in  2  PC register control code
  IFIDFlush  in  2  IF/ID register control code
  IDEXFlush  in  2  ID/EX register control code
  PCNext  in  32  next PC from PC-select mux
  InstIF  in  32  fetched instruction
  PCPlus4IF  in  32  PC+4 of fetched instruction
  CtrlID  in  16  decoded control bundle from ID
  RsID, RtID, RdID  in  5 each  register specifiers from ID
  PC  out  32  current PC
  InstID, PCPlus4ID  out  32 each  IF/ID contents
  ValidID  out  1  IF/ID holds a real instruction
  CtrlEX  out  16  ID/EX control bundle
  RsEX, RtEX, RdEX  out  5 each  ID/EX register specifiers
  PCPlus4EX  out  32  ID/EX PC+4
  ValidEX  out  1  ID/EX holds a real instruction
  StallCount  out  16  cycles with PC held
  FlushCount  out  16  cycles with any bubble inserted
  IllegalCode  out  1  sticky flag: code 2'b11 seen

Function
REQ-005 Each control code SHALL be decoded per rising edge: 2'b00 load, 2'b10 hold, 2'b01 clear, 2'b11 illegal.
REQ-006 PC register: 00 -> PC<=PCNext; 10 -> PC unchanged; 01 -> PC<=PCNext (clear not applicable to PC); 11 -> PC unchanged.
REQ-007 IF/ID register: 00 -> InstID<=InstIF, PCPlus4ID<=PCPlus4IF, ValidID<=1; 10 -> all unchanged; 01 -> InstID<=NOP_INST, PCPlus4ID<=0, ValidID<=0; 11 -> all unchanged.
REQ-008 ID/EX register: 00 -> capture CtrlID, Rs/Rt/RdID, PCPlus4ID, ValidEX<=ValidID; 10 -> unchanged; 01 -> CtrlEX<=0, Rs/Rt/RdEX<=0, PCPlus4EX<=0, ValidEX<=0; 11 -> unchanged.
REQ-009 ID/EX load SHALL force CtrlEX<=0 when ValidID=0, so a bubble never carries live control.
REQ-010 All three registers SHALL be updated independently on the same edge; latency IF->ID and ID->EX is one cycle each.
REQ-011 Load-use case (PCFlush=10, IFIDFlush=10, IDEXFlush=01 same cycle): PC and IF/ID hold, ID/EX becomes bubble.
REQ-012 Taken branch case (IFIDFlush=01, IDEXFlush=01, PCFlush=00): PC loads target, both IF/ID and ID/EX become bubbles.
REQ-013 StallCount SHALL increment by 1 on each edge where PCFlush=10, saturating at 16'hFFFF.
REQ-014 FlushCount SHALL increment by exactly 1 on each edge where IFIDFlush=01 or IDEXFlush=01 (both asserted counts once), saturating at 16'hFFFF.
REQ-015 IllegalCode SHALL set on any edge where any code equals 2'b11 and remain set until reset.
REQ-016 Counters SHALL not wrap; at 16'hFFFF further events leave value unchanged.

Reset
REQ-017 While reset=1, immediately and independent of clk: PC=RESET_PC, InstID=NOP_INST, all other data outputs 0, ValidID=0, ValidEX=0, counters 0, IllegalCode=0.
REQ-018 Reset asserted mid-stall or mid-flush SHALL override all codes; first edge after deassertion applies codes normally.

Verification
REQ-019 Reset release, codes 00, PCNext=0x00400004, InstIF=0x8C010000 -> after 1 edge PC=0x00400004, InstID=0x8C010000, ValidID=1; after 2nd edge ValidEX=1, CtrlEX=CtrlID.
REQ-020 Load-use: codes PC=10, IFID=10, IDEX=01 for one cycle -> PC and InstID unchanged, CtrlEX=0, ValidEX=0, StallCount=1, FlushCount=1.
REQ-021 Branch: IFID=01, IDEX=01, PCFlush=00, PCNext=0x00400100 -> PC=0x00400100, InstID=NOP_INST, ValidID=0, ValidEX=0, FlushCount +1 only.
REQ-022 Illegal: IFIDFlush=11 one cycle -> IF/ID unchanged, IllegalCode=1 and stays 1 after codes return to 00.
REQ-023 Saturation: hold PCFlush=10 for 65540 cycles -> StallCount=16'hFFFF, no wrap.
REQ-024 Async reset pulse between edges during a stall -> outputs at reset values before next clk edge; counters 0.
